// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit: alignment check, lane steering, load extension
// and a request/ack handshake with a wait-state bus, including error and timeout.
module mem_access_unit #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic            req_flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            exc_valid,
  output logic [4:0]      exc_code,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW/8-1:0] bus_be,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_ack,
  input  logic            bus_err,
  input  logic [DW-1:0]   bus_rdata
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          err_flag_reg;
  logic          cancel_flag_reg;
  logic [1:0]    size_reg;
  logic          signed_reg;
  logic [LB-1:0] lane_reg;
  logic          bus_req_reg;
  logic          bus_we_reg;
  logic [AW-1:0] bus_addr_reg;
  logic [NB-1:0] bus_be_reg;
  logic [DW-1:0] bus_wdata_reg;
  logic [DW-1:0] resp_rdata_reg;

  logic [LB-1:0] lane;
  logic          misaligned;
  logic          accept;
  logic          reject;
  logic [NB-1:0] be_next;
  logic [DW-1:0] rd_shifted;
  logic [DW-1:0] rd_mask;
  logic          rd_sign;
  logic [DW-1:0] rd_ext;

  assign lane = req_addr[LB-1:0];

  always_comb begin
    misaligned = 1'b0;
    be_next    = '0;
    case (req_size)
      2'd0: be_next = NB'(1) << lane;
      2'd1: begin
        misaligned = lane[0];
        be_next    = NB'(3) << lane;
      end
      2'd2: begin
        misaligned = (lane[1:0] != 2'b00);
        be_next    = NB'(15) << lane;
      end
      default: begin
        misaligned = (DW == 32) || (lane != '0);
        be_next    = '1;
      end
    endcase
  end

  assign accept = (state_reg == IDLE) && req_valid && !req_flush && !misaligned;
  assign reject = (state_reg == IDLE) && req_valid && !req_flush && misaligned;

  // Extension is done by masking the field and filling the upper bits with its sign.
  assign rd_shifted = bus_rdata >> {lane_reg, 3'b000};

  always_comb begin
    rd_mask = '1;
    rd_sign = 1'b0;
    case (size_reg)
      2'd0: begin rd_mask = DW'(8'hFF);         rd_sign = rd_shifted[7];  end
      2'd1: begin rd_mask = DW'(16'hFFFF);      rd_sign = rd_shifted[15]; end
      2'd2: begin rd_mask = DW'(32'hFFFF_FFFF); rd_sign = rd_shifted[31]; end
      default: begin rd_mask = '1;              rd_sign = 1'b0;           end
    endcase
  end

  assign rd_ext = (rd_shifted & rd_mask) | ((signed_reg && rd_sign) ? ~rd_mask : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      err_flag_reg    <= 1'b0;
      cancel_flag_reg <= 1'b0;
      size_reg        <= '0;
      signed_reg      <= 1'b0;
      lane_reg        <= '0;
      bus_req_reg     <= 1'b0;
      bus_we_reg      <= 1'b0;
      bus_addr_reg    <= '0;
      bus_be_reg      <= '0;
      bus_wdata_reg   <= '0;
      resp_rdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            bus_req_reg     <= 1'b1;
            bus_we_reg      <= req_we;
            bus_addr_reg    <= req_addr & ~AW'(NB - 1);
            bus_be_reg      <= be_next;
            bus_wdata_reg   <= req_wdata << {lane, 3'b000};
            size_reg        <= req_size;
            signed_reg      <= req_signed;
            lane_reg        <= lane;
            cnt_reg         <= '0;
            err_flag_reg    <= 1'b0;
            cancel_flag_reg <= 1'b0;
            state_reg       <= WAIT;
          end
        end
        WAIT: begin
          if (req_flush)
            cancel_flag_reg <= 1'b1;
          if (bus_err) begin
            err_flag_reg <= 1'b1;
            bus_req_reg  <= 1'b0;
            state_reg    <= DONE;
          end else if (bus_ack) begin
            // A cancelled load does not complete, so the previous load data is kept.
            if (!bus_we_reg && !cancel_flag_reg && !req_flush)
              resp_rdata_reg <= rd_ext;
            bus_req_reg <= 1'b0;
            state_reg   <= DONE;
          end else if (TIMEOUT > 0 && cnt_reg == CNT_LAST) begin
            err_flag_reg <= 1'b1;
            bus_req_reg  <= 1'b0;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    exc_code = 5'd0;
    if (reject)
      exc_code = req_we ? 5'd5 : 5'd4;
    else if (state_reg == DONE)
      exc_code = 5'd7;
  end

  assign stall      = accept || (state_reg == WAIT);
  assign resp_valid = (state_reg == DONE) && !err_flag_reg && !cancel_flag_reg;
  assign exc_valid  = reject || ((state_reg == DONE) && err_flag_reg && !cancel_flag_reg);
  assign resp_rdata = resp_rdata_reg;
  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_be     = bus_be_reg;
  assign bus_wdata  = bus_wdata_reg;

endmodule
